serial_engine_scheduler: RTL and testbench
==========================================

Name: serial_engine_scheduler

Overview:
Round-robin scheduler that shares one bit-serial two-flop Mealy detector engine among NREQ requesters. A granted requester hands over a DW-bit word. The block clears the engine, streams the word into it LSB first, and collects the engine's Mealy output one bit per cycle. It then returns the DW-bit result tagged with the requester ID. The engine itself sits outside this block and is driven through the eng_* ports.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, word width streamed per job (2..32)
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester level request; hold until matching req_ack
req_data  in  NREQ*DW  request words; requester i uses bits [i*DW +: DW]
req_ack  out  NREQ  one-hot, one-cycle pulse when requester's word is latched
eng_x  out  1  serial bit into engine
eng_rst  out  1  engine synchronous reset
eng_w  in  1  engine Mealy output; combinational from eng_x and engine state
rsp_valid  out  1  one-cycle pulse; result valid
rsp_id  out  IDW  requester index of the result
rsp_data  out  DW  collected engine outputs; bit k pairs with input bit k
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered except eng_rst, which is rst | (state==CLR).
- Reset values: state=IDLE, req_ack=0, eng_x=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, rr_ptr=NREQ-1 (so requester 0 wins first).
- FSM states: IDLE, CLR, SHIFT, DONE.
- IDLE: if any req bit is set, pick the winner g as the first set bit searching from rr_ptr+1 with wrap. On that edge latch shreg=req_data[g], id=g, rr_ptr=g, and go to CLR. With no req, stay in IDLE.
- CLR (1 cycle): req_ack[g]=1 and eng_rst=1; the engine's flops clear at the closing edge. Clear cnt and result. Go to SHIFT.
- SHIFT (DW cycles): eng_x=shreg[0]. Each edge captures result[cnt]=eng_w, shifts shreg right by one, and increments cnt. When cnt==DW-1, go to DONE.
- DONE (1 cycle): rsp_valid=1, rsp_data=result, rsp_id=id. Go to IDLE.
- rsp_data and rsp_id hold their values until the next DONE.
- eng_x=0 in every state except SHIFT.
- Latency: from the IDLE edge where req is sampled to the rsp_valid cycle is DW+2 edges. Job period is DW+3 cycles including the IDLE arbitration cycle.
- req changes after a grant are ignored until the next IDLE.
- A requester that keeps req high after its ack is treated as a new request; round-robin fairness still applies.
- A single requester holding req continuously is re-granted every DW+3 cycles.
- Data sampling: req_data of other requesters is not sampled. The winner's word is sampled only on its grant edge.
- rst mid-job: the job is aborted, no rsp_valid is issued, the FSM returns to IDLE, rr_ptr returns to NREQ-1, and eng_rst is asserted during rst.
- If req is high in the same cycle rst is released, it is serviced starting from the first cycle after release.

Optional Feature:
SCHED_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, lowest index wins, and rr_ptr is not used.
- Undefined: round-robin as described above.
- Timing and handshake are identical in both builds.

Test Plan:
The bench connects the team's two-flop serial detector engine: v0'=x&(v0|v1), v1'=x&~v1, W=~x&(v0|v1).
1. Single request: req[0]=1 with data 0x55 -> req_ack=0001 in the CLR cycle; rsp_valid 10 edges after sampling; rsp_data=0xAA, rsp_id=0; busy high throughout the job.
2. Data 0x03 on requester 2 -> rsp_data=0x04, rsp_id=2. Data 0xF0 -> rsp_data=0x00.
3. req=1111 held with distinct data per requester -> grant order 0,1,2,3,0; rsp_id follows the same order; each job takes 11 cycles.
4. Engine clear between jobs: job A with data 0x01 leaves the engine state at 00 and rsp_data=0x02. Immediately follow with job B carrying 0x55 -> B's rsp_data=0xAA, with eng_rst=1 exactly in B's CLR cycle.
5. Mid-job reset: assert rst during SHIFT cnt=4 -> no rsp_valid; outputs at reset values; the next req[3] alone is served normally.
6. Build with SCHED_FIXED_PRIO_EN and req=1010 held -> requester 1 is granted every time and requester 3 is never granted.

Source files
------------

// File: rtl/serial_engine_scheduler.sv
// serial_engine_scheduler: shares one external bit-serial Mealy engine among NREQ requesters, round-robin.
// Define SCHED_FIXED_PRIO_EN to arbitrate by fixed priority (lowest index wins) instead.
module serial_engine_scheduler #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic                 eng_x,
  output logic                 eng_rst,
  input  logic                 eng_w,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic                 busy
);
  localparam int CW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] shreg, shreg_n, result, result_n, rsp_data_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IDW-1:0] id, id_n, rr_ptr, rr_ptr_n, g, idx, rsp_id_n;
  logic [NREQ-1:0] req_ack_n;
  logic eng_x_n, rsp_valid_n, busy_n;
  logic [DW-1:0] words [NREQ];
  for (genvar j = 0; j < NREQ; j++) begin : g_words
    assign words[j] = req_data[j*DW +: DW];
  end
  always_comb begin
    g = '0;
    idx = '0;
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'(i);
      g = req[idx] ? idx : g;
    end
`else
    // walk backwards from rr_ptr so the nearest set bit after rr_ptr is the last to win
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(rr_ptr) + i) % NREQ);
      g = req[idx] ? idx : g;
    end
`endif
  end
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    result_n = result;
    cnt_n = cnt;
    id_n = id;
    rr_ptr_n = rr_ptr;
    req_ack_n = '0;
    rsp_valid_n = 1'b0;
    rsp_id_n = rsp_id;
    rsp_data_n = rsp_data;
    case (state)
      IDLE: if (|req) begin
        state_n = CLR;
        shreg_n = words[g];
        id_n = g;
        rr_ptr_n = g;
        req_ack_n = NREQ'(1) << g;
      end
      CLR: begin
        state_n = SHIFT;
        cnt_n = '0;
        result_n = '0;
      end
      SHIFT: begin
        result_n[cnt] = eng_w;
        shreg_n = shreg >> 1;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(DW - 1)) begin
          state_n = DONE;
          rsp_valid_n = 1'b1;
          rsp_data_n = result_n;
          rsp_id_n = id;
        end
      end
      default: state_n = IDLE;
    endcase
    eng_x_n = (state_n == SHIFT) ? shreg_n[0] : 1'b0;
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      result <= '0;
      cnt <= '0;
      id <= '0;
      rr_ptr <= IDW'(NREQ - 1);
      req_ack <= '0;
      eng_x <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      result <= result_n;
      cnt <= cnt_n;
      id <= id_n;
      rr_ptr <= rr_ptr_n;
      req_ack <= req_ack_n;
      eng_x <= eng_x_n;
      rsp_valid <= rsp_valid_n;
      rsp_id <= rsp_id_n;
      rsp_data <= rsp_data_n;
      busy <= busy_n;
    end
  end
  assign eng_rst = rst | (state == CLR);
endmodule

// File: tb/tb_serial_engine_scheduler.sv
// tb_serial_engine_scheduler: scoreboard bench with the two-flop detector engine attached.
module tb_serial_engine_scheduler;
  localparam int NREQ = 4;
  localparam int DW = 8;
  logic clk = 0;
  logic rst;
  logic [3:0] req, req_ack, hold;
  logic [31:0] req_data;
  logic eng_x, eng_rst, eng_w, rsp_valid, busy;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;
  logic v0, v1;
  logic en;
  int tests = 0, fails = 0;
  int rem = 0, rr = NREQ - 1, cur_g = 0;
  int last_id = 0;
  logic [7:0] last_data = 0;
  typedef struct {int id; logic [7:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  always #5 clk = ~clk;

  serial_engine_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
    .eng_x(eng_x), .eng_rst(eng_rst), .eng_w(eng_w), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always_ff @(posedge clk) begin
    if (eng_rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      v0 <= eng_x & (v0 | v1);
      v1 <= eng_x & ~v1;
    end
  end
  assign eng_w = ~eng_x & (v0 | v1);

  function automatic logic [7:0] eng_ref(logic [7:0] d);
    logic a = 0, b = 0, x;
    logic [7:0] r = 0;
    for (int k = 0; k < DW; k++) begin
      x = d[k];
      r[k] = ~x & (a | b);
      {a, b} = {x & (a | b), x & ~b};
    end
    return r;
  endfunction

  function automatic int pick(logic [3:0] r, int p);
`ifdef SCHED_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return 0;
  endfunction

  // Job model: a granted job occupies DW+2 cycles after its arbitration edge
  always @(posedge clk) begin
    if (rst) begin
      rem = 0;
      rr = NREQ - 1;
      exp_q.delete();
    end else if (rem > 0) begin
      rem--;
    end else if (req != 0) begin
      cur_g = pick(req, rr);
      rr = cur_g;
      exp_q.push_back('{cur_g, eng_ref(req_data[cur_g*8 +: 8])});
      rem = DW + 2;
    end
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (en) begin
      if (rst) begin
        last_id = 0;
        last_data = 0;
      end
      chk("busy", 32'(busy), 32'(rem > 0));
      chk("req_ack", 32'(req_ack), (rem == DW + 2) ? 32'(1) << cur_g : 32'(0));
      chk("eng_rst", 32'(eng_rst), 32'(rst || rem == DW + 2));
      chk("rsp_valid", 32'(rsp_valid), 32'(rem == 1));
      if (!(rem >= 2 && rem <= DW + 1)) chk("eng_x_idle", 32'(eng_x), 32'(0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(1), 32'(0));
        else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_data", 32'(rsp_data), 32'(e.data));
          last_id = e.id;
          last_data = e.data;
        end
      end else begin
        chk("rsp_id_hold", 32'(rsp_id), 32'(last_id));
        chk("rsp_data_hold", 32'(rsp_data), 32'(last_data));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (req_ack[i]) begin
        if (hold[i]) req_data[i*8 +: 8] = 8'($urandom);
        else req[i] = 1'b0;
      end
  endtask

  initial begin
    rst = 1; req = 0; req_data = 0; hold = 0; en = 0;
    repeat (2) step();
    en = 1;
    step();
    rst = 0;
    req_data[7:0] = 8'h55; req = 4'b0001;
    repeat (14) step();
    req_data[23:16] = 8'h03; req[2] = 1;
    repeat (13) step();
    req_data[23:16] = 8'hF0; req[2] = 1;
    repeat (13) step();
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(8'h11 * (i + 1));
    hold = 4'hF; req = 4'hF;
    repeat (60) step();
    hold = 0;
    repeat (50) step();
    // back-to-back jobs on one requester: engine must be cleared between them
    req_data[7:0] = 8'h01; hold[0] = 1; req[0] = 1;
    repeat (3) step();
    req_data[7:0] = 8'h55; hold[0] = 0;
    repeat (25) step();
    req_data[15:8] = 8'($urandom); req[1] = 1;
    for (int k = 0; k < 20 && rem != 5; k++) step();
    rst = 1;
    repeat (3) step();
    rst = 0; req = 4'b1000; req_data[31:24] = 8'h3C;
    repeat (14) step();
    hold = 4'b1010; req = 4'b1010;
    repeat (50) step();
    hold = 0;
    repeat (30) step();
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 0) hold = 4'($urandom);
      for (int i = 0; i < 4; i++)
        if (!req[i]) begin
          req_data[i*8 +: 8] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1;
        end
      step();
    end
    req = 0; hold = 0;
    repeat (30) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
